// File: rtl/sm4_tau_serial.sv
// SM4 tau (S-box layer) driver: serialises a 32-bit word through one shared byte S-box,
// gathers the substituted bytes in order and applies L (round) or L' (key schedule).
module sm4_tau_serial #(
  parameter int SBOX_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data,
  input  logic        i_key_mode,
  output logic [7:0]  o_sb_data,
  output logic        o_sb_valid,
  input  logic [7:0]  i_sb_data,
  input  logic        i_sb_valid,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  localparam logic [7:0] TMO_LAST = 8'(SBOX_TIMEOUT - 1);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] l_xform(input logic [31:0] b);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] lp_xform(input logic [31:0] b);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  state_t            state_q, state_d;
  logic [3:0][7:0]   word_q, word_d;
  logic              mode_q, mode_d;
  logic [2:0]        iss_cnt_q, iss_cnt_d;
  logic [2:0]        rsp_cnt_q, rsp_cnt_d;
  logic [3:0][7:0]   b_q, b_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic [7:0]        sb_data_q, sb_data_d;
  logic              sb_valid_q, sb_valid_d;
  logic              valid_q, valid_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;

  logic [3:0][7:0]   b_merged;
  logic [1:0]        slot;
  logic              rsp_fire;

  // Responses arrive in issue order, so the response count alone picks the byte slot.
  assign slot     = 2'd3 - rsp_cnt_q[1:0];
  assign rsp_fire = i_sb_valid && (state_q == ISSUE || state_q == WAIT);

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign b_merged[gi] = (slot == 2'(gi)) ? i_sb_data : b_q[gi];
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    mode_d     = mode_q;
    iss_cnt_d  = iss_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    b_d        = b_q;
    tmo_cnt_d  = tmo_cnt_q;
    sb_data_d  = sb_data_q;
    sb_valid_d = sb_valid_q;
    valid_d    = valid_q;
    data_d     = data_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          word_d     = i_data;
          mode_d     = i_key_mode;
          iss_cnt_d  = 3'd1;
          rsp_cnt_d  = 3'd0;
          tmo_cnt_d  = 8'd0;
          sb_valid_d = 1'b1;
          sb_data_d  = i_data[31:24];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (iss_cnt_q == 3'd4) begin
          sb_valid_d = 1'b0;
          sb_data_d  = 8'd0;
          state_d    = WAIT;
        end else begin
          sb_data_d = word_q[2'd3 - iss_cnt_q[1:0]];
          iss_cnt_d = iss_cnt_q + 3'd1;
        end
      end
      WAIT: begin
        if (!i_sb_valid) begin
          if (tmo_cnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
        end
      end
      OUT: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Response capture overrides the per-state decisions; the 4th byte finishes the word.
    if (rsp_fire) begin
      b_d       = b_merged;
      rsp_cnt_d = rsp_cnt_q + 3'd1;
      tmo_cnt_d = 8'd0;
      if (rsp_cnt_q == 3'd3) begin
        data_d     = mode_q ? lp_xform(b_merged) : l_xform(b_merged);
        valid_d    = 1'b1;
        sb_valid_d = 1'b0;
        sb_data_d  = 8'd0;
        state_d    = OUT;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      mode_q     <= 1'b0;
      iss_cnt_q  <= 3'd0;
      rsp_cnt_q  <= 3'd0;
      b_q        <= '0;
      tmo_cnt_q  <= 8'd0;
      sb_data_q  <= 8'd0;
      sb_valid_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      mode_q     <= mode_d;
      iss_cnt_q  <= iss_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      b_q        <= b_d;
      tmo_cnt_q  <= tmo_cnt_d;
      sb_data_q  <= sb_data_d;
      sb_valid_q <= sb_valid_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_sb_data  = sb_data_q;
  assign o_sb_valid = sb_valid_q;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_sm4_tau_serial.sv
// Bench for sm4_tau_serial: byte S-box stub with optional jitter/mute, reference tau model,
// directed cases plus randomized words.
module tb_sm4_tau_serial;

  localparam int TMO = 15;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data = 32'd0;
  logic        i_key_mode = 1'b0;
  logic [7:0]  o_sb_data;
  logic        o_sb_valid;
  logic [7:0]  i_sb_data = 8'd0;
  logic        i_sb_valid = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_data;
  logic        o_err;

  sm4_tau_serial #(.SBOX_TIMEOUT(TMO)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_key_mode (i_key_mode),
    .o_sb_data  (o_sb_data),
    .o_sb_valid (o_sb_valid),
    .i_sb_data  (i_sb_data),
    .i_sb_valid (i_sb_valid),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_err      (o_err)
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] sbox [256];
  logic [7:0] rsp_q [$];
  logic       stub_mute = 1'b0;
  logic       stub_jitter = 1'b0;
  int         hold_cnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} << n;
    return d[63:32];
  endfunction

  function automatic logic [31:0] ref_l(input logic [31:0] b);
    int amt [4] = '{2, 10, 18, 24};
    logic [31:0] r = b;
    foreach (amt[i]) r ^= rotl(b, amt[i]);
    return r;
  endfunction

  function automatic logic [31:0] ref_lp(input logic [31:0] b);
    int amt [2] = '{13, 23};
    logic [31:0] r = b;
    foreach (amt[i]) r ^= rotl(b, amt[i]);
    return r;
  endfunction

  function automatic logic [31:0] ref_tau(input logic [31:0] w, input logic m);
    logic [31:0] b = 32'd0;
    for (int i = 0; i < 4; i++) b = (b << 8) | {24'd0, sbox[w[31-8*i -: 8]]};
    return m ? ref_lp(b) : ref_l(b);
  endfunction

  // Registered S-box stub: in-order queue, at least one cycle of latency, optional random gaps.
  initial begin
    forever begin
      @(posedge i_clk);
      if (o_sb_valid && !stub_mute) rsp_q.push_back(sbox[o_sb_data]);
      if (rsp_q.size() > 0 && (!stub_jitter || hold_cnt >= 2 || $urandom_range(1, 0) == 1)) begin
        i_sb_valid <= 1'b1;
        i_sb_data  <= rsp_q.pop_front();
        hold_cnt = 0;
      end else begin
        i_sb_valid <= 1'b0;
        if (rsp_q.size() > 0) hold_cnt++;
      end
    end
  end

  task automatic run_word(input logic [31:0] w, input logic m, input logic [31:0] exp,
                          input int rdy_hold, input bit chk_lat);
    logic [7:0]  seen [$];
    int          lat;
    logic [31:0] held;
    lat = -1;
    @(negedge i_clk);
    check("ready_idle", {31'd0, o_ready}, 32'd1);
    i_valid    = 1'b1;
    i_data     = w;
    i_key_mode = m;
    @(posedge i_clk);
    #1;
    i_valid    = 1'b0;
    i_data     = $urandom;
    i_key_mode = ~m;
    for (int j = 0; j < 60; j++) begin
      @(negedge i_clk);
      if (o_sb_valid) seen.push_back(o_sb_data);
      if (o_valid) begin
        lat = j;
        break;
      end
    end
    check("valid_seen", {31'd0, lat >= 0}, 32'd1);
    if (lat < 0) return;
    check("sb_count", seen.size(), 32'd4);
    for (int b = 0; b < 4 && b < seen.size(); b++)
      check("sb_byte", {24'd0, seen[b]}, {24'd0, w[31-8*b -: 8]});
    if (chk_lat) check("latency", lat, 32'd5);
    check("data", o_data, exp);
    check("err", {31'd0, o_err}, {31'd0, exp_err});
    check("ready_out", {31'd0, o_ready}, 32'd0);
    held    = o_data;
    i_valid = 1'b1;
    i_data  = $urandom;
    for (int h = 0; h < rdy_hold; h++) begin
      @(negedge i_clk);
      check("hold_valid", {31'd0, o_valid}, 32'd1);
      check("hold_data", o_data, held);
      check("hold_ready", {31'd0, o_ready}, 32'd0);
    end
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    i_valid = 1'b0;
    check("drop_valid", {31'd0, o_valid}, 32'd0);
    check("idle_ready", {31'd0, o_ready}, 32'd1);
    check("no_accept", {31'd0, o_sb_valid}, 32'd0);
    $display("[TB] word %h mode %0d -> %h (expected %h)", w, m, held, exp);
  endtask

  task automatic timeout_test();
    @(negedge i_clk);
    stub_mute = 1'b1;
    i_valid   = 1'b1;
    i_data    = $urandom;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    for (int k = 1; k <= 4 + TMO; k++) begin
      @(posedge i_clk);
      #1;
      check("tmo_err", {31'd0, o_err}, (k >= 4 + TMO) ? 32'd1 : 32'd0);
      check("tmo_valid", {31'd0, o_valid}, 32'd0);
    end
    exp_err = 1'b1;
    check("tmo_ready", {31'd0, o_ready}, 32'd1);
    @(negedge i_clk);
    stub_mute = 1'b0;
    $display("[TB] timeout word discarded, err=%0d", o_err);
  endtask

  task automatic reset_test();
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = $urandom;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_sb_valid", {31'd0, o_sb_valid}, 32'd0);
    check("rst_sb_data", {24'd0, o_sb_data}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    exp_err = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (3) begin
      @(posedge i_clk);
      #1;
      check("late_valid", {31'd0, o_valid}, 32'd0);
      check("late_sb_valid", {31'd0, o_sb_valid}, 32'd0);
      check("late_ready", {31'd0, o_ready}, 32'd1);
    end
    $display("[TB] mid-operation reset done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic        m;
    for (int i = 0; i < 256; i++) sbox[i] = 8'($urandom);
    sbox[0] = 8'hD6;
    sbox[1] = 8'h90;
    sbox[2] = 8'hE9;
    sbox[3] = 8'hFE;

    repeat (2) @(posedge i_clk);
    #1;
    check("init_ready", {31'd0, o_ready}, 32'd1);
    check("init_sb_valid", {31'd0, o_sb_valid}, 32'd0);
    check("init_sb_data", {24'd0, o_sb_data}, 32'd0);
    check("init_valid", {31'd0, o_valid}, 32'd0);
    check("init_data", o_data, 32'd0);
    check("init_err", {31'd0, o_err}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;

    run_word(32'h00000000, 1'b0, 32'h5B5B5B5B, 0, 1'b1);
    run_word(32'h00000000, 1'b1, 32'h67676767, 0, 1'b1);
    run_word(32'h00010203, 1'b0, ref_l(32'hD690E9FE), 0, 1'b1);
    w = $urandom;
    run_word(w, 1'b1, ref_tau(w, 1'b1), 3, 1'b1);

    stub_jitter = 1'b1;
    repeat (20) begin
      w = $urandom;
      m = 1'($urandom_range(1, 0));
      run_word(w, m, ref_tau(w, m), $urandom_range(3, 0), 1'b0);
    end
    stub_jitter = 1'b0;
    repeat (4) @(posedge i_clk);

    timeout_test();
    w = $urandom;
    run_word(w, 1'b0, ref_tau(w, 1'b0), 1, 1'b1);

    reset_test();
    w = $urandom;
    run_word(w, 1'b1, ref_tau(w, 1'b1), 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
